// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - round-robin arbiter sharing one L2 request port between I-side and D-side L1 caches
module l2_port_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    input  logic               I_L2_read,
    input  logic               I_L2_write,
    input  logic [27:0]        I_L2_addr,
    input  logic [127:0]       I_L2_wdata,
    output logic [127:0]       I_L2_rdata,
    output logic               I_L2_ready,
    input  logic               D_L2_read,
    input  logic               D_L2_write,
    input  logic [27:0]        D_L2_addr,
    input  logic [127:0]       D_L2_wdata,
    output logic [127:0]       D_L2_rdata,
    output logic               D_L2_ready,
    output logic               L2_read,
    output logic               L2_write,
    output logic [27:0]        L2_addr,
    output logic [127:0]       L2_wdata,
    input  logic [127:0]       L2_rdata,
    input  logic               L2_ready,
    output logic               arb_timeout,
    output logic [CNT_W-1:0]   arb_cnt_i,
    output logic [CNT_W-1:0]   arb_cnt_d
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              op_read_q, op_read_d;
    logic              op_write_q, op_write_d;
    logic [27:0]       addr_q, addr_d;
    logic [127:0]      wdata_q, wdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_i_q, cnt_i_d;
    logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;

    // A master requests only when exactly one of read/write is asserted
    logic i_valid, d_valid, grant;
    assign i_valid = I_L2_read ^ I_L2_write;
    assign d_valid = D_L2_read ^ D_L2_write;
    // On a tie the master that did not win last time gets the port
    assign grant   = (i_valid && d_valid) ? ~last_grant_q : d_valid;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            op_read_q    <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            cnt_i_q      <= '0;
            cnt_d_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_read_q    <= op_read_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            cnt_i_q      <= cnt_i_d;
            cnt_d_q      <= cnt_d_d;
        end
    end

    // Next-state: arbitrate and latch in IDLE, hold and run the watchdog in BUSY
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_read_d    = op_read_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wd_d         = wd_q;
        timeout_d    = timeout_q;
        cnt_i_d      = cnt_i_q;
        cnt_d_d      = cnt_d_q;
        case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_d      = BUSY;
                    owner_d      = grant;
                    last_grant_d = grant;
                    wd_d         = '0;
                    if (grant == OWN_D) begin
                        op_read_d  = D_L2_read;
                        op_write_d = D_L2_write;
                        addr_d     = D_L2_addr;
                        wdata_d    = D_L2_wdata;
                        if (cnt_d_q != CNT_MAX) cnt_d_d = cnt_d_q + CNT_W'(1);
                    end else begin
                        op_read_d  = I_L2_read;
                        op_write_d = I_L2_write;
                        addr_d     = I_L2_addr;
                        wdata_d    = I_L2_wdata;
                        if (cnt_i_q != CNT_MAX) cnt_i_d = cnt_i_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (L2_ready) begin
                    state_d = IDLE;
                end else begin
                    if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
                    // The grant is never aborted; the flag only records a stall
                    if (wd_d >= WD_LIMIT) timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: L2 side from latched request, completion routed to the owner only
    always_comb begin
        L2_read    = 1'b0;
        L2_write   = 1'b0;
        L2_addr    = '0;
        L2_wdata   = '0;
        I_L2_ready = 1'b0;
        I_L2_rdata = '0;
        D_L2_ready = 1'b0;
        D_L2_rdata = '0;
        if (state_q == BUSY) begin
            L2_read  = op_read_q;
            L2_write = op_write_q;
            L2_addr  = addr_q;
            L2_wdata = wdata_q;
            if (L2_ready) begin
                if (owner_q == OWN_D) begin
                    D_L2_ready = 1'b1;
                    D_L2_rdata = L2_rdata;
                end else begin
                    I_L2_ready = 1'b1;
                    I_L2_rdata = L2_rdata;
                end
            end
        end
    end

    assign arb_timeout = timeout_q;
    assign arb_cnt_i   = cnt_i_q;
    assign arb_cnt_d   = cnt_d_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - directed self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic              clk;
    logic              proc_reset_n;
    logic              I_L2_read, I_L2_write, D_L2_read, D_L2_write;
    logic [27:0]       I_L2_addr, D_L2_addr, L2_addr;
    logic [127:0]      I_L2_wdata, D_L2_wdata, I_L2_rdata, D_L2_rdata, L2_wdata, L2_rdata;
    logic              I_L2_ready, D_L2_ready, L2_read, L2_write, L2_ready, arb_timeout;
    logic [CNT_W-1:0]  arb_cnt_i, arb_cnt_d;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] RD1  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] RD2  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] PATA = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] PATB = 128'h01020304_05060708_090A0B0C_0D0E0F10;

    l2_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .I_L2_read(I_L2_read), .I_L2_write(I_L2_write), .I_L2_addr(I_L2_addr),
        .I_L2_wdata(I_L2_wdata), .I_L2_rdata(I_L2_rdata), .I_L2_ready(I_L2_ready),
        .D_L2_read(D_L2_read), .D_L2_write(D_L2_write), .D_L2_addr(D_L2_addr),
        .D_L2_wdata(D_L2_wdata), .D_L2_rdata(D_L2_rdata), .D_L2_ready(D_L2_ready),
        .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
        .L2_rdata(L2_rdata), .L2_ready(L2_ready),
        .arb_timeout(arb_timeout), .arb_cnt_i(arb_cnt_i), .arb_cnt_d(arb_cnt_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        I_L2_read = 0; I_L2_write = 0; I_L2_addr = '0; I_L2_wdata = '0;
        D_L2_read = 0; D_L2_write = 0; D_L2_addr = '0; D_L2_wdata = '0;
        L2_ready = 0; L2_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset_n = 0;
        clear_inputs();
        step();
        proc_reset_n = 1;
    endtask

    task automatic test_reset();
        proc_reset_n = 0;
        clear_inputs();
        step();
        step();
        tests++; if (L2_read !== 1'b0 || L2_write !== 1'b0) begin fails++; $display("FAIL rst_l2_op got %b%b exp 00", L2_read, L2_write); end
        tests++; if (L2_addr !== 28'h0 || L2_wdata !== 128'h0) begin fails++; $display("FAIL rst_l2_addr got %h exp 0", L2_addr); end
        tests++; if (I_L2_ready !== 1'b0 || D_L2_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b exp 00", I_L2_ready, D_L2_ready); end
        tests++; if (arb_cnt_i !== 2'd0 || arb_cnt_d !== 2'd0 || arb_timeout !== 1'b0) begin fails++; $display("FAIL rst_dbg got %0d %0d %b exp 0 0 0", arb_cnt_i, arb_cnt_d, arb_timeout); end
        proc_reset_n = 1;
    endtask

    task automatic test_i_only_read();
        do_reset();
        I_L2_read = 1; I_L2_addr = 28'h0000010;
        #1;
        tests++; if (L2_read !== 1'b0) begin fails++; $display("FAIL t1_idle_read got %b exp 0", L2_read); end
        step();
        tests++; if (L2_read !== 1'b1 || L2_addr !== 28'h0000010) begin fails++; $display("FAIL t1_l2_req got %b %h exp 1 0000010", L2_read, L2_addr); end
        tests++; if (I_L2_ready !== 1'b0) begin fails++; $display("FAIL t1_early_ready got %b exp 0", I_L2_ready); end
        L2_ready = 1; L2_rdata = RD1;
        #1;
        tests++; if (I_L2_ready !== 1'b1 || I_L2_rdata !== RD1) begin fails++; $display("FAIL t1_i_resp got %b %h exp 1 %h", I_L2_ready, I_L2_rdata, RD1); end
        tests++; if (D_L2_ready !== 1'b0 || D_L2_rdata !== 128'h0) begin fails++; $display("FAIL t1_d_quiet got %b %h exp 0 0", D_L2_ready, D_L2_rdata); end
        tests++; if (arb_cnt_i !== 2'd1) begin fails++; $display("FAIL t1_cnt_i got %0d exp 1", arb_cnt_i); end
        step();
        I_L2_read = 0; L2_ready = 0;
        #1;
        tests++; if (L2_read !== 1'b0) begin fails++; $display("FAIL t1_back_idle got %b exp 0", L2_read); end
    endtask

    task automatic test_round_robin();
        do_reset();
        I_L2_read = 1; I_L2_addr = 28'h0000100;
        D_L2_read = 1; D_L2_addr = 28'h0000200;
        step();
        tests++; if (L2_addr !== 28'h0000100) begin fails++; $display("FAIL t2_first_i got %h exp 0000100", L2_addr); end
        L2_ready = 1; L2_rdata = RD2;
        #1;
        tests++; if (I_L2_ready !== 1'b1 || D_L2_ready !== 1'b0 || D_L2_rdata !== 128'h0) begin fails++; $display("FAIL t2_i_done got %b %b %h exp 1 0 0", I_L2_ready, D_L2_ready, D_L2_rdata); end
        step();
        I_L2_read = 0; L2_ready = 0;
        step();
        tests++; if (L2_read !== 1'b1 || L2_addr !== 28'h0000200) begin fails++; $display("FAIL t2_second_d got %b %h exp 1 0000200", L2_read, L2_addr); end
        L2_ready = 1; L2_rdata = RD1;
        #1;
        tests++; if (D_L2_ready !== 1'b1 || D_L2_rdata !== RD1 || I_L2_ready !== 1'b0) begin fails++; $display("FAIL t2_d_done got %b %h %b exp 1 %h 0", D_L2_ready, D_L2_rdata, I_L2_ready, RD1); end
        step();
        I_L2_read = 1; L2_ready = 0;
        step();
        tests++; if (L2_addr !== 28'h0000100) begin fails++; $display("FAIL t2_third_i got %h exp 0000100", L2_addr); end
        tests++; if (arb_cnt_i !== 2'd2 || arb_cnt_d !== 2'd1) begin fails++; $display("FAIL t2_counts got %0d %0d exp 2 1", arb_cnt_i, arb_cnt_d); end
        L2_ready = 1;
        step();
        I_L2_read = 0; D_L2_read = 0; L2_ready = 0;
        step();
    endtask

    task automatic test_latching();
        do_reset();
        D_L2_write = 1; D_L2_addr = 28'h0ABCDEF; D_L2_wdata = PATA;
        step();
        D_L2_addr = 28'h0000001; D_L2_wdata = PATB; D_L2_write = 0; D_L2_read = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (L2_write !== 1'b1 || L2_read !== 1'b0 || L2_addr !== 28'h0ABCDEF || L2_wdata !== PATA) begin
                fails++; $display("FAIL t3_hold_%0d got %b%b %h %h exp 01 0abcdef %h", k, L2_read, L2_write, L2_addr, L2_wdata, PATA);
            end
            if (k == 4) begin
                L2_ready = 1;
                #1;
                tests++; if (D_L2_ready !== 1'b1) begin fails++; $display("FAIL t3_done got %b exp 1", D_L2_ready); end
            end
            step();
        end
        D_L2_read = 0; L2_ready = 0;
        step();
    endtask

    task automatic test_illegal();
        do_reset();
        I_L2_read = 1; I_L2_write = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            tests++; if (L2_read !== 1'b0 || L2_write !== 1'b0) begin fails++; $display("FAIL t4_no_grant_%0d got %b%b exp 00", k, L2_read, L2_write); end
        end
        tests++; if (arb_cnt_i !== 2'd0) begin fails++; $display("FAIL t4_cnt_i got %0d exp 0", arb_cnt_i); end
        I_L2_read = 0; I_L2_write = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        I_L2_read = 1; I_L2_addr = 28'h0000020;
        for (int k = 0; k < 4; k++) begin
            step();
            L2_ready = 1;
            step();
            L2_ready = 0;
        end
        I_L2_read = 0;
        #1;
        tests++; if (arb_cnt_i !== 2'd3 || arb_cnt_d !== 2'd0) begin fails++; $display("FAIL t_sat_counts got %0d %0d exp 3 0", arb_cnt_i, arb_cnt_d); end
        step();
    endtask

    task automatic test_watchdog();
        do_reset();
        D_L2_read = 1; D_L2_addr = 28'h0000300;
        step();
        for (int k = 1; k <= 7; k++) step();
        tests++; if (arb_timeout !== 1'b0) begin fails++; $display("FAIL t5_early_timeout got %b exp 0", arb_timeout); end
        step();
        tests++; if (arb_timeout !== 1'b1) begin fails++; $display("FAIL t5_timeout got %b exp 1", arb_timeout); end
        L2_ready = 1; L2_rdata = RD2;
        #1;
        tests++; if (D_L2_ready !== 1'b1 || D_L2_rdata !== RD2) begin fails++; $display("FAIL t5_late_done got %b %h exp 1 %h", D_L2_ready, D_L2_rdata, RD2); end
        step();
        D_L2_read = 0; L2_ready = 0;
        step();
        step();
        tests++; if (arb_timeout !== 1'b1 || L2_read !== 1'b0) begin fails++; $display("FAIL t5_sticky got %b %b exp 1 0", arb_timeout, L2_read); end
    endtask

    task automatic test_reset_mid_busy();
        I_L2_read = 1; I_L2_addr = 28'h0000040;
        step();
        tests++; if (L2_read !== 1'b1) begin fails++; $display("FAIL t6_busy got %b exp 1", L2_read); end
        proc_reset_n = 0;
        step();
        tests++; if (L2_read !== 1'b0 || arb_cnt_i !== 2'd0 || arb_cnt_d !== 2'd0 || arb_timeout !== 1'b0) begin
            fails++; $display("FAIL t6_after_rst got %b %0d %0d %b exp 0 0 0 0", L2_read, arb_cnt_i, arb_cnt_d, arb_timeout);
        end
        proc_reset_n = 1;
        step();
        tests++; if (L2_read !== 1'b1 || L2_addr !== 28'h0000040 || arb_cnt_i !== 2'd1) begin
            fails++; $display("FAIL t6_regrant got %b %h %0d exp 1 0000040 1", L2_read, L2_addr, arb_cnt_i);
        end
        L2_ready = 1;
        step();
        I_L2_read = 0; L2_ready = 0;
        step();
    endtask

    initial begin
        clear_inputs();
        proc_reset_n = 0;
        test_reset();
        test_i_only_read();
        test_round_robin();
        test_latching();
        test_illegal();
        test_saturation();
        test_watchdog();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
